// File: rtl/sram_ctrl.sv
// sram_ctrl: single-command controller for an asynchronous SRAM.
//
// Handshake: a host command (we/addr/wdata) transfers on a rising clk edge
// where req && ready. ready is high only while idle; req seen while busy is
// dropped, not queued, so the host keeps req asserted until it is taken.
// Completion is a one-cycle done pulse; read data is then held in rdata.
//
// Parameters
//   WR_PULSE  cycles sram_wr is held high per write (1..15)
//   RD_WAIT   cycles sram_rd is held low per read   (1..15)
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req, we, addr,      host command; we=1 write, we=0 read
//   wdata
//   ready, done, rdata  host status / completion / last read result
//   sram_addr, sram_din SRAM address and write data, held for the command
//   sram_dout           SRAM read data
//   sram_cs             chip select, active high
//   sram_rd             read strobe, active low
//   sram_wr             write strobe, active high
//   fsm_state           current FSM state, for observation
//
// Every output is a flop: the strobes are registered from the next-state
// value so they line up with the state they belong to.
module sram_ctrl #(
  parameter int WR_PULSE = 1,
  parameter int RD_WAIT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] sram_addr,
  output logic [7:0] sram_din,
  input  logic [7:0] sram_dout,
  output logic       sram_cs,
  output logic       sram_rd,
  output logic       sram_wr,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WR_STB  = 3'd2,
    RD_STB  = 3'd3,
    RECOVER = 3'd4
  } state_t;

  // Counter is loaded with (cycles - 1) on entry to a strobe state and the
  // state is left when it reads zero, so the strobe lasts exactly 'cycles'.
  localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q;
  logic       accept;
  logic       load_rdata;

  assign fsm_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    load_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (we_q) begin
          state_d = WR_STB;
          cnt_d   = WR_LOAD;
        end else begin
          state_d = RD_STB;
          cnt_d   = RD_LOAD;
        end
      end
      WR_STB: begin
        if (cnt_q == 4'd0) state_d = RECOVER;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RD_STB: begin
        // sram_dout is still valid on the edge that ends the last cycle.
        if (cnt_q == 4'd0) begin
          state_d    = RECOVER;
          load_rdata = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) we_q <= we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= 1'b1;
      done      <= 1'b0;
      sram_cs   <= 1'b0;
      sram_rd   <= 1'b1;
      sram_wr   <= 1'b0;
      rdata     <= 8'h00;
      sram_addr <= 8'h00;
      sram_din  <= 8'h00;
    end else begin
      ready   <= (state_d == IDLE);
      done    <= (state_d == RECOVER);
      sram_cs <= (state_d == SETUP) || (state_d == WR_STB) || (state_d == RD_STB);
      sram_rd <= (state_d != RD_STB);
      sram_wr <= (state_d == WR_STB);
      if (load_rdata) rdata <= sram_dout;
      if (accept) begin
        sram_addr <= addr;
        sram_din  <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: bench for sram_ctrl. Two instances: defaults (WR_PULSE=1,
// RD_WAIT=2) and a sweep (WR_PULSE=3, RD_WAIT=1), each with a behavioural
// SRAM. 'sel' routes the host command to one instance and picks its outputs.
module tb_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       sel = 1'b0;

  logic       req0, req1;
  logic       ready0, done0, cs0, rd0, wr0;
  logic       ready1, done1, cs1, rd1, wr1;
  logic [7:0] rdata0, sa0, sd0, dout0, lat0;
  logic [7:0] rdata1, sa1, sd1, dout1, lat1;
  logic [2:0] st0, st1;

  assign req0 = req & ~sel;
  assign req1 = req & sel;

  sram_ctrl #(.WR_PULSE(1), .RD_WAIT(2)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready0), .done(done0), .rdata(rdata0), .sram_addr(sa0),
    .sram_din(sd0), .sram_dout(dout0), .sram_cs(cs0), .sram_rd(rd0),
    .sram_wr(wr0), .fsm_state(st0)
  );

  sram_ctrl #(.WR_PULSE(3), .RD_WAIT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready1), .done(done1), .rdata(rdata1), .sram_addr(sa1),
    .sram_din(sd1), .sram_dout(dout1), .sram_cs(cs1), .sram_rd(rd1),
    .sram_wr(wr1), .fsm_state(st1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural SRAMs ----------------
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  always @(posedge wr0) if (cs0 && rd0) mem0[sa0] = sd0;
  always @(negedge rd0) if (cs0) lat0 = mem0[sa0];
  assign dout0 = (cs0 && !rd0) ? lat0 : 8'h00;

  always @(posedge wr1) if (cs1 && rd1) mem1[sa1] = sd1;
  always @(negedge rd1) if (cs1) lat1 = mem1[sa1];
  assign dout1 = (cs1 && !rd1) ? lat1 : 8'h00;

  // ---------------- selected-instance view ----------------
  logic       o_ready, o_done, o_cs, o_rd, o_wr;
  logic [7:0] o_rdata, o_sa, o_sd;
  assign o_ready = sel ? ready1 : ready0;
  assign o_done  = sel ? done1  : done0;
  assign o_cs    = sel ? cs1    : cs0;
  assign o_rd    = sel ? rd1    : rd0;
  assign o_wr    = sel ? wr1    : wr0;
  assign o_rdata = sel ? rdata1 : rdata0;
  assign o_sa    = sel ? sa1    : sa0;
  assign o_sd    = sel ? sd1    : sd0;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] ref0 [256];
  logic [7:0] ref1 [256];
  int n_err = 0;
  int n_chk = 0;

  // Per-command observations collected by run_cmd.
  int obs_done_cyc, obs_done_cnt, obs_ready_cyc;
  int obs_cs, obs_wr, obs_rdlow, obs_viol, obs_addr_bad, obs_setup_bad;
  logic [7:0] obs_rdata;

  // ---------------- driver ----------------
  // Called at a negedge. Waits for ready, presents one command, then samples
  // one cycle per negedge until ready returns. Cycle n is the n-th cycle
  // after the accept edge. keep=1 leaves req high for back-to-back use.
  // Read results are popped from exp_q and compared when done is seen.
  task automatic run_cmd(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic keep);
    int k;
    logic [7:0] e;
    k = 0;
    while (!o_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!o_ready) begin
      n_chk++; n_err++;
      $display("FAIL ready_wait: ready=%0b, required 1 within 50 cycles", o_ready);
      return;
    end
    we = w; addr = a; wdata = d; req = 1'b1;
    if (w) begin
      if (sel) ref1[a] = d; else ref0[a] = d;
    end else begin
      exp_q.push_back(sel ? ref1[a] : ref0[a]);
    end
    obs_done_cyc = 0; obs_done_cnt = 0; obs_ready_cyc = 0;
    obs_cs = 0; obs_wr = 0; obs_rdlow = 0; obs_viol = 0;
    obs_addr_bad = 0; obs_setup_bad = 0; obs_rdata = 8'h00;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (!keep) req = 1'b0;
        if (o_ready || !o_cs || o_wr || !o_rd) obs_setup_bad++;
      end
      if (o_cs) obs_cs++;
      if (o_wr) obs_wr++;
      if (!o_rd) obs_rdlow++;
      if ((o_wr && !o_rd) || ((o_wr || !o_rd) && !o_cs)) obs_viol++;
      if (o_sa !== a || o_sd !== d) obs_addr_bad++;
      if (o_done) begin
        obs_done_cnt++;
        obs_done_cyc = n;
        obs_rdata = o_rdata;
        if (!w) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_rdata: read done with empty expected queue");
          end else begin
            e = exp_q.pop_front();
            if (o_rdata !== e) begin
              n_err++;
              $display("FAIL sb_rdata: addr=%02h rdata=%02h, required %02h", a, o_rdata, e);
            end
          end
        end
      end
      if (o_ready) begin
        obs_ready_cyc = n;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({ready0, done0, cs0, rd0, wr0, rdata0, sa0, sd0} !== {5'b10010, 24'h0}) begin
      n_err++;
      $display("FAIL reset_dut0: rdy/done/cs/rd/wr=%b%b%b%b%b rdata=%02h addr=%02h din=%02h, required 10010 00 00 00",
               ready0, done0, cs0, rd0, wr0, rdata0, sa0, sd0);
    end
    n_chk++;
    if ({ready1, done1, cs1, rd1, wr1, rdata1, sa1, sd1} !== {5'b10010, 24'h0}) begin
      n_err++;
      $display("FAIL reset_dut1: rdy/done/cs/rd/wr=%b%b%b%b%b rdata=%02h addr=%02h din=%02h, required 10010 00 00 00",
               ready1, done1, cs1, rd1, wr1, rdata1, sa1, sd1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    sel = 1'b0;
    run_cmd(1'b1, 8'h3C, 8'hA5, 1'b0);
    n_chk++;
    if (obs_done_cyc != 3 || obs_done_cnt != 1 || obs_ready_cyc != 4) begin
      n_err++;
      $display("FAIL wr_latency: done_cyc=%0d done_cnt=%0d ready_cyc=%0d, required 3 1 4",
               obs_done_cyc, obs_done_cnt, obs_ready_cyc);
    end
    n_chk++;
    if (obs_cs != 2 || obs_wr != 1 || obs_rdlow != 0 || obs_viol != 0 || obs_setup_bad != 0) begin
      n_err++;
      $display("FAIL wr_strobes: cs=%0d wr=%0d rdlow=%0d viol=%0d setup_bad=%0d, required 2 1 0 0 0",
               obs_cs, obs_wr, obs_rdlow, obs_viol, obs_setup_bad);
    end
    run_cmd(1'b0, 8'h3C, 8'h00, 1'b0);
    n_chk++;
    if (obs_done_cyc != 4 || obs_done_cnt != 1 || obs_ready_cyc != 5) begin
      n_err++;
      $display("FAIL rd_latency: done_cyc=%0d done_cnt=%0d ready_cyc=%0d, required 4 1 5",
               obs_done_cyc, obs_done_cnt, obs_ready_cyc);
    end
    n_chk++;
    if (obs_cs != 3 || obs_wr != 0 || obs_rdlow != 2 || obs_viol != 0 || obs_addr_bad != 0) begin
      n_err++;
      $display("FAIL rd_strobes: cs=%0d wr=%0d rdlow=%0d viol=%0d addr_bad=%0d, required 3 0 2 0 0",
               obs_cs, obs_wr, obs_rdlow, obs_viol, obs_addr_bad);
    end
    // A later write must leave rdata alone.
    run_cmd(1'b1, 8'h3C, 8'h5A, 1'b0);
    n_chk++;
    if (rdata0 !== 8'hA5) begin
      n_err++;
      $display("FAIL rdata_hold: rdata=%02h after write, required a5", rdata0);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    sel = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      run_cmd(1'b1, 8'(i), 8'(i) ^ 8'hC3, 1'b1);
      if (obs_done_cyc != 3 || obs_ready_cyc != 4 || obs_done_cnt != 1 ||
          obs_setup_bad != 0 || obs_viol != 0 || obs_addr_bad != 0) bad++;
    end
    for (int i = 0; i < 256; i++) begin
      run_cmd(1'b0, 8'(i), 8'h00, 1'b1);
      if (obs_done_cyc != 4 || obs_ready_cyc != 5 || obs_done_cnt != 1 ||
          obs_setup_bad != 0 || obs_viol != 0 || obs_addr_bad != 0) bad++;
    end
    req = 1'b0;
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL b2b_timing: %0d commands with wrong timing/strobes/address, required 0", bad);
    end
  endtask

  task automatic test_busy_ignore();
    int dn, cs_n, abad;
    logic [7:0] e;
    sel = 1'b0;
    dn = 0; cs_n = 0; abad = 0;
    we = 1'b0; addr = 8'h10; wdata = 8'h00; req = 1'b1;
    exp_q.push_back(ref0[8'h10]);
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (o_cs) cs_n++;
      if (o_sa !== 8'h10) abad++;
      if (o_done) begin
        dn++;
        n_chk++;
        e = exp_q.pop_front();
        if (o_rdata !== e) begin
          n_err++;
          $display("FAIL busy_rdata: rdata=%02h, required %02h", o_rdata, e);
        end
      end
      if (n == 1) req = 1'b0;
      if (n == 2) begin req = 1'b1; addr = 8'h11; end
      if (n == 3) req = 1'b0;
    end
    n_chk++;
    if (dn != 1 || cs_n != 3 || abad != 0) begin
      n_err++;
      $display("FAIL busy_ignore: done_cnt=%0d cs_cycles=%0d addr_bad=%0d, required 1 3 0", dn, cs_n, abad);
    end
  endtask

  task automatic test_mid_read_reset();
    int dn;
    sel = 1'b0;
    we = 1'b0; addr = 8'h3C; wdata = 8'h00; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({rd0, cs0, wr0, done0, ready0, rdata0, sa0} !== {5'b10001, 16'h0}) begin
      n_err++;
      $display("FAIL mid_reset: rd/cs/wr/done/rdy=%b%b%b%b%b rdata=%02h addr=%02h, required 10001 00 00",
               rd0, cs0, wr0, done0, ready0, rdata0, sa0);
    end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done0 || cs0) dn++;
    end
    n_chk++;
    if (dn != 0) begin
      n_err++;
      $display("FAIL mid_reset_quiet: %0d cycles with done/cs after reset, required 0", dn);
    end
    run_cmd(1'b0, 8'h3C, 8'h00, 1'b0);
    n_chk++;
    if (obs_done_cyc != 4 || obs_done_cnt != 1) begin
      n_err++;
      $display("FAIL post_reset_read: done_cyc=%0d done_cnt=%0d, required 4 1", obs_done_cyc, obs_done_cnt);
    end
  endtask

  task automatic test_param_sweep();
    sel = 1'b1;
    run_cmd(1'b1, 8'h55, 8'h77, 1'b0);
    n_chk++;
    if (obs_done_cyc != 5 || obs_ready_cyc != 6 || obs_cs != 4 || obs_wr != 3 || obs_viol != 0) begin
      n_err++;
      $display("FAIL sweep_wr: done_cyc=%0d ready_cyc=%0d cs=%0d wr=%0d viol=%0d, required 5 6 4 3 0",
               obs_done_cyc, obs_ready_cyc, obs_cs, obs_wr, obs_viol);
    end
    run_cmd(1'b1, 8'h56, 8'h88, 1'b0);
    run_cmd(1'b0, 8'h55, 8'h00, 1'b0);
    n_chk++;
    if (obs_done_cyc != 3 || obs_ready_cyc != 4 || obs_cs != 2 || obs_rdlow != 1 || obs_viol != 0) begin
      n_err++;
      $display("FAIL sweep_rd: done_cyc=%0d ready_cyc=%0d cs=%0d rdlow=%0d viol=%0d, required 3 4 2 1 0",
               obs_done_cyc, obs_ready_cyc, obs_cs, obs_rdlow, obs_viol);
    end
    run_cmd(1'b0, 8'h56, 8'h00, 1'b0);
    n_chk++;
    if (rdata1 !== 8'h88) begin
      n_err++;
      $display("FAIL sweep_data: rdata=%02h, required 88", rdata1);
    end
    sel = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00; mem1[i] = 8'h00;
      ref0[i] = 8'h00; ref1[i] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_busy_ignore();
    test_mid_read_reset();
    test_param_sweep();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected reads never completed, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
